// File: rtl/uart_wb_master.sv
// uart_wb_master: UART-byte-stream driven single-beat Wishbone initiator.
// Frames: 'W' ADDR[4] DATA[4] -> one write, replies ACK_BYTE.
//         'R' ADDR[4]         -> one read, replies the read word MSB first.
// Optional feature macro: UART_WB_TIMEOUT_EN (bus-cycle timeout, replies ERR_BYTE).
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ADDR  | shifting in 4 address bytes
// WDATA | shifting in 4 write-data bytes
// BUS   | Wishbone cycle in progress, waiting for ack
// RESP  | sending the response byte(s)
module uart_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;

  logic [2:0]  state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;        // frame byte index, then remaining tx bytes
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdat_q, rdat_d;      // read word still to be sent, MSB aligned
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        cmd_err_q, cmd_err_d;

`ifdef UART_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Next-state logic: frame parsing, bus cycle and response sequencing
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rdat_d     = rdat_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cmd_err_d  = 1'b0;
`ifdef UART_WB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_W || rx_data == OP_R) begin
            is_wr_d = (rx_data == OP_W);
            cnt_d   = 2'd0;
            state_d = S_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_ADDR, S_WDATA: begin
        if (rx_valid) begin
          if (state_q == S_ADDR) adr_d = {adr_q[23:0], rx_data};
          else                   dat_d = {dat_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && is_wr_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_BUS;
              cyc_d   = 1'b1;
              we_d    = is_wr_q;
              sel_d   = 4'hF;
`ifdef UART_WB_TIMEOUT_EN
              tmo_d   = '0;
`endif
            end
          end
        end
      end
      S_BUS: begin
        if (rx_valid) cmd_err_d = 1'b1;
        if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = 4'h0;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
          if (is_wr_q) begin
            tx_data_d = ACK_BYTE;
            cnt_d     = 2'd0;
          end else begin
            tx_data_d = wbm_dat_i[31:24];
            rdat_d    = {wbm_dat_i[23:0], 8'h00};
            cnt_d     = 2'd3;
          end
        end
`ifdef UART_WB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = 4'h0;
          cmd_err_d  = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = ERR_BYTE;
          cnt_d      = 2'd0;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rx_valid) cmd_err_d = 1'b1;
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = rdat_q[31:24];
            rdat_d    = {rdat_q[23:0], 8'h00};
            cnt_d     = cnt_q - 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= 2'd0;
      adr_q      <= 32'h0;
      dat_q      <= 32'h0;
      rdat_q     <= 32'h0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
`ifdef UART_WB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rdat_q     <= rdat_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
`ifdef UART_WB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Testbench for uart_wb_master: directed frames, Wishbone slave model and
// scoreboards for expected bus transactions and transmitted bytes.
module tb_uart_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;
  logic        busy, cmd_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } wb_exp_t;

  wb_exp_t    wbq[$];
  logic [7:0] txq[$];

  int          ack_delay = 2;      // 0 = slave never acks
  logic [31:0] rdata = 32'h0;
  int          wait_cnt = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          tx_cnt = 0;
  int          err_cnt = 0;
  logic        ack_prev = 1'b0;

  uart_wb_master #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wishbone slave model: acks ack_delay cycles into the cycle, checks the request
  always @(negedge clk) begin
    if (ack_prev) begin
      check("cyc_drop_after_ack", {31'h0, cyc}, 32'h0);
      ack = 1'b0;
      ack_prev = 1'b0;
    end
    if (cyc) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len = 0;
    end
    if (cyc && stb && !ack) begin
      wait_cnt++;
      if (ack_delay != 0 && wait_cnt == ack_delay) begin
        ack = 1'b1;
        ack_prev = 1'b1;
        dat_i = rdata;
        if (wbq.size() == 0) begin
          check("wb_unexpected_cycle", adr, 32'hxxxxxxxx);
        end else begin
          wb_exp_t e;
          e = wbq.pop_front();
          check("wb_adr", adr, e.adr);
          check("wb_we", {31'h0, we}, {31'h0, e.we});
          check("wb_sel", {28'h0, sel}, 32'hF);
          if (e.we) check("wb_dat", dat_o, e.dat);
        end
      end
    end else if (!cyc) begin
      wait_cnt = 0;
    end
  end

  // Transmit-side scoreboard and cmd_err pulse counter
  always @(negedge clk) begin
    if (cmd_err) err_cnt++;
    if (!rst && tx_valid && tx_ready) begin
      tx_cnt++;
      if (txq.size() == 0) check("tx_unexpected_byte", {24'h0, tx_data}, 32'hxxxxxxxx);
      else check("tx_byte", {24'h0, tx_data}, {24'h0, txq.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(busy === 1'b0 && txq.size() == 0 && wbq.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'h0, (n < 300)}, 32'h1);
  endtask

  task automatic wait_sig(input string tag, input int which);
    int n;
    n = 0;
    while (((which == 0) ? cyc : tx_valid) !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'h0, (n < 100)}, 32'h1);
  endtask

  initial begin
    int t0, e0;
    wb_exp_t e;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_cyc_stb_we", {29'h0, cyc, stb, we}, 32'h0);
    check("rst_sel", {28'h0, sel}, 32'h0);
    check("rst_adr", adr, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_busy_err", {30'h0, busy, cmd_err}, 32'h0);

    // write with ack two cycles after stb
    e.adr = 32'h3000_0004; e.dat = 32'hDEAD_BEEF; e.we = 1'b1;
    wbq.push_back(e);
    txq.push_back(8'h4B);
    t0 = tx_cnt;
    ack_delay = 2;
    send_write(32'h3000_0004, 32'hDEAD_BEEF);
    check("wr_cyc_after_last_byte", {30'h0, cyc, stb}, 32'h3);
    check("wr_busy_in_bus", {31'h0, busy}, 32'h1);
    wait_done("wr_done");
    check("wr_tx_count", tx_cnt - t0, 1);
    check("wr_cyc_len", last_len, 2);
    check("wr_busy_idle", {31'h0, busy}, 32'h0);

    // read
    e.adr = 32'h3000_0008; e.dat = 32'h0; e.we = 1'b0;
    wbq.push_back(e);
    txq.push_back(8'h12); txq.push_back(8'h34); txq.push_back(8'h56); txq.push_back(8'h78);
    rdata = 32'h1234_5678;
    ack_delay = 1;
    t0 = tx_cnt;
    send_read(32'h3000_0008);
    wait_done("rd_done");
    check("rd_tx_count", tx_cnt - t0, 4);

    // read with tx_ready held low for 10 cycles
    e.adr = 32'h3000_000C;
    wbq.push_back(e);
    txq.push_back(8'h12); txq.push_back(8'h34); txq.push_back(8'h56); txq.push_back(8'h78);
    tx_ready = 1'b0;
    ack_delay = 3;
    t0 = tx_cnt;
    send_read(32'h3000_000C);
    wait_sig("bp_tx_valid", 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h12});
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_done("bp_done");
    check("bp_tx_count", tx_cnt - t0, 4);

    // bad opcode then a valid write
    e0 = err_cnt;
    send_byte(8'h41);
    @(posedge clk); #1;
    check("bad_op_err", err_cnt - e0, 1);
    check("bad_op_idle", {31'h0, busy}, 32'h0);
    e.adr = 32'h3000_0010; e.dat = 32'h0BAD_F00D; e.we = 1'b1;
    wbq.push_back(e);
    txq.push_back(8'h4B);
    ack_delay = 2;
    send_write(32'h3000_0010, 32'h0BAD_F00D);
    wait_done("bad_op_wr_done");
    check("bad_op_err_once", err_cnt - e0, 1);

`ifdef UART_WB_TIMEOUT_EN
    // read with no ack expires after 16 cycles in BUS
    e0 = err_cnt;
    ack_delay = 0;
    txq.push_back(8'h45);
    t0 = tx_cnt;
    send_read(32'h3000_0014);
    wait_done("tmo_done");
    check("tmo_cyc_len", last_len, 16);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_tx_count", tx_cnt - t0, 1);
    // ack on the expiry cycle wins
    e0 = err_cnt;
    ack_delay = 16;
    rdata = 32'hCAFE_0123;
    e.adr = 32'h3000_0018; e.we = 1'b0;
    wbq.push_back(e);
    txq.push_back(8'hCA); txq.push_back(8'hFE); txq.push_back(8'h01); txq.push_back(8'h23);
    send_read(32'h3000_0018);
    wait_done("tmo_ack_done");
    check("tmo_ack_no_err", err_cnt - e0, 0);
`endif

    // reset during BUS
    ack_delay = 0;
    send_read(32'h3000_001C);
    wait_sig("rstbus_cyc", 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstbus_outputs", {28'h0, cyc, stb, tx_valid, busy}, 32'h0);
    rst = 1'b0;

    // reset during RESP
    ack_delay = 1;
    rdata = 32'h5555_AAAA;
    tx_ready = 1'b0;
    e.adr = 32'h3000_0020; e.we = 1'b0;
    wbq.push_back(e);
    send_read(32'h3000_0020);
    wait_sig("rstresp_tx_valid", 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstresp_outputs", {28'h0, cyc, stb, tx_valid, busy}, 32'h0);
    rst = 1'b0;
    tx_ready = 1'b1;

    // normal frame after resets
    e.adr = 32'h3000_0024; e.dat = 32'h1122_3344; e.we = 1'b1;
    wbq.push_back(e);
    txq.push_back(8'h4B);
    ack_delay = 2;
    send_write(32'h3000_0024, 32'h1122_3344);
    wait_done("post_rst_done");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Host-side Wishbone initiator driven by a UART byte stream. It is the master counterpart of the UART-attached Wishbone slave peripherals.
- Sits between the uart_receive/uart_transmission byte interfaces and a 32-bit Wishbone bus. It lets an external host peek and poke any bus address, e.g. the 0x3000_00xx user region.
- Parses fixed-length command frames, runs exactly one single-beat Wishbone cycle per frame, and returns the result as bytes.

Parameters:
- TIMEOUT_CYCLES, 1024: bus cycles to wait for wbm_ack_i before aborting. Used only with the optional feature.
- ACK_BYTE, 8'h4B: response byte for a completed write.
- ERR_BYTE, 8'h45: response byte for an aborted (timed-out) access.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter can accept a byte
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  1 = write
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  Wishbone acknowledge
- busy  out  1  high whenever the FSM is not in IDLE
- cmd_err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Interface decision: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: all outputs 0 (tx_data 8'h00, wbm_* 0, busy 0, cmd_err 0); FSM in IDLE; byte counter, timeout counter and data shift register cleared.
- Reset mid-operation: all of the above take effect at the next edge. This includes dropping cyc/stb mid-cycle and discarding any pending tx byte.
- Frame formats (multi-byte fields MSB first):
  - Write: 'W' (8'h57), ADDR[31:24..7:0], DATA[31:24..7:0]. Nine bytes.
  - Read: 'R' (8'h52), ADDR x4. Five bytes.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
  - IDLE: rx_valid with 'W' or 'R' latches the opcode, clears the byte counter and goes to ADDR. Any other byte is dropped, cmd_err pulses, FSM stays in IDLE.
  - ADDR: each rx_valid shifts the byte into wbm_adr_o (shift left by 8). After the 4th byte, go to WDATA if the opcode is 'W', else to BUS.
  - WDATA: the same shifting into wbm_dat_o. After the 4th byte, go to BUS.
  - BUS: cyc=stb=1, we = (opcode=='W'), sel=4'hF. Last frame byte at edge N gives cyc/stb high in cycle N+1.
    - On wbm_ack_i sampled high at edge M: cyc/stb/we drop at M; for a read, wbm_dat_i is captured at M. Go to RESP; tx_valid is high from cycle M+1.
    - Ack is level-sampled only while in BUS; ack outside BUS is ignored.
  - RESP:
    - Write: sends one byte, ACK_BYTE.
    - Read: sends 4 bytes, captured data MSB first.
    - A byte transfers on an edge where tx_valid && tx_ready. The next byte is presented in the following cycle, so there is no bubble beyond one cycle.
    - tx_data is stable while tx_valid is high and not accepted.
    - After the final transfer: tx_valid=0, go to IDLE.
- rx_valid while in BUS or RESP: byte dropped, cmd_err pulses, state unaffected.
- There is no inter-byte timeout in ADDR/WDATA; a partial frame waits indefinitely, cleared only by reset.
- The address is driven unmodified; there is no alignment check.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_WB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each cycle in BUS.
  - If it reaches TIMEOUT_CYCLES with no ack, cyc/stb drop at that edge and cmd_err pulses.
  - RESP then sends the single byte ERR_BYTE, for both read and write.
  - An ack arriving in the same cycle as expiry wins (normal completion).
- Undefined: there is no counter, and BUS waits for ack forever.

Test Plan:
- Write: bytes 57 30 00 00 04 DE AD BE EF, slave acks 2 cycles after stb -> one WB write, adr=0x30000004, dat=0xDEADBEEF, sel=F, we=1; tx emits 4B; busy returns to 0.
- Read: bytes 52 30 00 00 08, slave returns 0x12345678 -> we=0, cyc for exactly 1 cycle after ack; tx emits 12 34 56 78 in order.
- tx_ready low for 10 cycles during a read response -> tx_data holds 12 until accepted; no bytes are lost or duplicated; total 4 transfers.
- Bad opcode 0x41, then a valid write frame -> cmd_err pulses once; the write then completes normally with response 4B.
- With UART_WB_TIMEOUT_EN and TIMEOUT_CYCLES=16: read with no ack -> cyc drops after 16 cycles in BUS, cmd_err pulses, tx emits 45 only. Repeat with ack on cycle 16 -> normal 4-byte response.
- wb_rst_i asserted mid-BUS and mid-RESP -> cyc/stb/tx_valid are 0 next cycle; a subsequent frame works normally.
